// File: rtl/fixed_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fixed_pkg
// Purpose  : Shared definitions for the Q8.8 fixed-point divider: default
//            operand widths, saturation limits and the divider state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fixed_pkg;

  // Default format is Q8.8 in a 16-bit two's-complement word.
  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 8;

  // Saturation limits of the default format.
  localparam logic [DATA_W_DEF-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W_DEF-1:0] Q_MIN = 16'h8000;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIX    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fixed_div_step.sv
`default_nettype none
// ============================================================================
// Module   : fixed_div_step
// Purpose  : One combinational restoring-division step. The partial remainder
//            is shifted left with the next dividend bit appended; if the
//            result is not below the divisor magnitude it is reduced and a
//            quotient bit of 1 is produced.
// Ports    : rem_in  [DATA_W-1:0] partial remainder (always < dmag)
//            bit_in               next dividend bit, shifted in at the LSB
//            dmag    [DATA_W:0]   divisor magnitude (17 bits for |-32768|)
//            rem_out [DATA_W-1:0] updated partial remainder
//            q_bit                quotient bit for this step
// Revision : 1.0 - initial release
// ============================================================================
module fixed_div_step #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic              bit_in,
  input  logic [DATA_W:0]   dmag,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  // rem_in < dmag <= 2^(DATA_W-1), so the shifted trial value fits in
  // DATA_W+1 bits and the restored remainder always fits back into DATA_W.
  logic [DATA_W:0] w_trial;

  assign w_trial = {rem_in, bit_in};
  assign q_bit   = (w_trial >= dmag);
  assign rem_out = q_bit ? DATA_W'(w_trial - dmag) : w_trial[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/fixed_div.sv
`default_nettype none
// ============================================================================
// Module   : fixed_div
// Purpose  : Sequential signed Q(DATA_W-FRAC_W).FRAC_W divider. Restoring
//            shift-subtract core producing one magnitude quotient bit per
//            clock, followed by a sign/saturation fix-up cycle. Valid/ready
//            handshake on both sides, one operation in flight.
// Ports    : clk          rising-edge clock
//            rst_n        asynchronous active-low reset
//            in_valid     operands present
//            in_ready     divider idle, operands will be accepted
//            dividend     [DATA_W-1:0] numerator
//            divisor      [DATA_W-1:0] denominator
//            out_valid    result available, held until accepted
//            out_ready    consumer accepts result
//            quotient     [DATA_W-1:0] truncated toward zero, saturated
//            overflow     result saturated because of range
//            div_by_zero  divisor was zero
// Revision : 1.0 - initial release
// ============================================================================
module fixed_div
  import fixed_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic              overflow,
  output logic              div_by_zero
);

  // Scaled dividend width: |dividend| << FRAC_W.
  localparam int WORK_W = DATA_W + FRAC_W;
  localparam int CNT_W  = $clog2(WORK_W);

  localparam logic [CNT_W-1:0]  c_count_init = CNT_W'(WORK_W - 1);
  localparam logic [CNT_W-1:0]  c_cnt_one    = CNT_W'(1);
  localparam logic [DATA_W-1:0] c_one        = DATA_W'(1);
  localparam logic [DATA_W-1:0] c_zero       = '0;
  localparam logic [DATA_W-1:0] c_q_max      = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] c_q_min      = {1'b1, {(DATA_W-1){1'b0}}};
  // Largest magnitudes representable for a positive / negative result.
  localparam logic [WORK_W-1:0] c_pos_lim    = WORK_W'(c_q_max);
  localparam logic [WORK_W-1:0] c_neg_lim    = WORK_W'(c_q_min);

  state_t              r_state;
  state_t              w_next;

  logic [DATA_W-1:0]   r_rem;
  logic [WORK_W-1:0]   r_work;      // dividend bits shift out, quotient bits shift in
  logic [DATA_W:0]     r_dmag;
  logic [CNT_W-1:0]    r_count;
  logic                r_neg;       // result sign
  logic                r_dvd_neg;   // dividend sign, selects the dbz limit
  logic                r_dbz;

  logic                w_accept;
  logic                w_dvs_zero;
  logic [DATA_W-1:0]   w_dvd_mag;
  logic [DATA_W-1:0]   w_dvs_mag;
  logic [DATA_W-1:0]   w_rem_next;
  logic                w_q_bit;
  logic [DATA_W-1:0]   w_q_low;
  logic [DATA_W-1:0]   w_fix_q;
  logic                w_fix_ovf;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_dvs_zero = (divisor == c_zero);

  // Magnitudes as unsigned DATA_W values; the most negative input maps to
  // 2^(DATA_W-1), which is still representable unsigned.
  assign w_dvd_mag = dividend[DATA_W-1] ? (~dividend + c_one) : dividend;
  assign w_dvs_mag = divisor[DATA_W-1]  ? (~divisor  + c_one) : divisor;

  fixed_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_in  (r_rem),
    .bit_in  (r_work[WORK_W-1]),
    .dmag    (r_dmag),
    .rem_out (w_rem_next),
    .q_bit   (w_q_bit)
  );

  // Sign application and saturation of the finished magnitude quotient.
  assign w_q_low = r_work[DATA_W-1:0];

  always_comb begin
    w_fix_q   = c_zero;
    w_fix_ovf = 1'b0;
    if (r_dbz) begin
      w_fix_q = r_dvd_neg ? c_q_min : c_q_max;
    end else if (!r_neg && (r_work > c_pos_lim)) begin
      w_fix_q   = c_q_max;
      w_fix_ovf = 1'b1;
    end else if (r_neg && (r_work > c_neg_lim)) begin
      w_fix_q   = c_q_min;
      w_fix_ovf = 1'b1;
    end else begin
      // Negating a zero magnitude gives zero, so no negative-zero case exists.
      w_fix_q = r_neg ? (~w_q_low + c_one) : w_q_low;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_dvs_zero ? FIX : DIVIDE;
        end
      end
      DIVIDE: begin
        if (r_count == '0) begin
          w_next = FIX;
        end
      end
      FIX: begin
        w_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_work      <= '0;
      r_dmag      <= '0;
      r_count     <= '0;
      r_neg       <= 1'b0;
      r_dvd_neg   <= 1'b0;
      r_dbz       <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem     <= '0;
            r_work    <= {w_dvd_mag, {FRAC_W{1'b0}}};
            r_dmag    <= {1'b0, w_dvs_mag};
            r_count   <= c_count_init;
            r_neg     <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
            r_dvd_neg <= dividend[DATA_W-1];
            r_dbz     <= w_dvs_zero;
          end
        end
        DIVIDE: begin
          r_rem   <= w_rem_next;
          r_work  <= {r_work[WORK_W-2:0], w_q_bit};
          r_count <= r_count - c_cnt_one;
        end
        FIX: begin
          quotient    <= w_fix_q;
          overflow    <= w_fix_ovf;
          div_by_zero <= r_dbz;
        end
        default: begin
          // DONE: results held stable until and after acceptance.
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fixed_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_div
// Purpose  : Self-checking bench for fixed_div. Directed operand pairs with
//            hand-computed results and latencies, plus a signed-arithmetic
//            reference model checked on every cycle the result is valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_div;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  int          tests = 0;
  int          fails = 0;

  logic        exp_pending = 1'b0;
  logic [15:0] exp_q       = '0;
  logic        exp_ovf     = 1'b0;
  logic        exp_dbz     = 1'b0;

  fixed_div #(
    .DATA_W (16),
    .FRAC_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: real-valued quotient scaled by 2^8, truncated toward zero
  // (integer division), then clamped to the 16-bit signed range.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
    longint      n;
    longint      d;
    longint      r;
    logic [15:0] q;
    logic        ovf;
    logic        dbz;
    n   = longint'($signed(a));
    d   = longint'($signed(b));
    ovf = 1'b0;
    dbz = 1'b0;
    if (d == 0) begin
      dbz = 1'b1;
      q   = (n >= 0) ? 16'h7FFF : 16'h8000;
    end else begin
      r = (n * 256) / d;
      if (r > 32767) begin
        q = 16'h7FFF; ovf = 1'b1;
      end else if (r < -32768) begin
        q = 16'h8000; ovf = 1'b1;
      end else begin
        q = r[15:0];
      end
    end
    return {q, ovf, dbz};
  endfunction

  // Continuous comparison whenever a result is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_pending) begin
        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        check("model_quotient", {16'd0, quotient}, {16'd0, exp_q});
        check("model_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        check("model_dbz", {31'd0, div_by_zero}, {31'd0, exp_dbz});
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] lit_q, input logic lit_ovf, input logic lit_dbz,
                       input int lit_lat, input int hold);
    int          n;
    int          lat;
    logic [17:0] m;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);                     // acceptance edge
    m           = model(a, b);
    exp_q       = m[17:2];
    exp_ovf     = m[1];
    exp_dbz     = m[0];
    exp_pending = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    // Latency counted in cycles, the acceptance cycle being cycle 1.
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, lit_lat);
    check("model_pin", {14'd0, m}, {14'd0, lit_q, lit_ovf, lit_dbz});
    check("lit_quotient", {16'd0, quotient}, {16'd0, lit_q});
    check("lit_overflow", {31'd0, overflow}, {31'd0, lit_ovf});
    check("lit_dbz", {31'd0, div_by_zero}, {31'd0, lit_dbz});
    // Backpressure, with ignored operand pulses while busy.
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      dividend = 16'h1234;
      divisor  = 16'h0001;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("held_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    exp_pending = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_accept_valid", {31'd0, out_valid}, 32'd0);
    check("post_accept_ready", {31'd0, in_ready}, 32'd1);
    check("post_accept_hold", {16'd0, quotient}, {16'd0, lit_q});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 26, 0);  //  3 / 2
    do_op(16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 26, 0);  // -3 / 2
    do_op(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 26, 0);  //  1 / 3
    do_op(16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 26, 0);  // -1 / 3
    do_op(16'h7FFF, 16'h0080, 16'h7FFF, 1'b1, 1'b0, 26, 0);  // ~128 / 0.5
    do_op(16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 26, 0);  // -128 / 1
    do_op(16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 26, 0);  // -128 / -1
    do_op(16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 26, 0);  // tiny negative -> 0
    do_op(16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 2, 0);   //  1 / 0
    do_op(16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 2, 0);   //  0 / 0
    do_op(16'h1000, 16'h0400, 16'h0400, 1'b0, 1'b0, 26, 10); // 16 / 4, backpressure
    do_op(16'hF000, 16'h0000, 16'h8000, 1'b0, 1'b1, 2, 0);   // -16 / 0

    // Reset during DIVIDE: operation lost, outputs clear immediately.
    in_valid = 1'b1;
    dividend = 16'h0300;
    divisor  = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_quotient", {16'd0, quotient}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);         // lost operation must never complete
    check("midrst_no_result", {31'd0, out_valid}, 32'd0);
    do_op(16'h0200, 16'h0100, 16'h0200, 1'b0, 1'b0, 26, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
